// File: rtl/asgn_binop_pkg.sv
// Shared types for the compound-assignment accumulator engine: opcodes, FSM states, decode helper.
package asgn_binop_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_MOD  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_SSHL = 4'd11,
    OP_SSHR = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] OP_LAST_LEGAL = 4'd12;

  // DIV and MOD take the iterative divider path; everything else is single-cycle.
  function automatic logic is_divmod(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/asgn_binop_acc_if.sv
// Command/response bus of the accumulator engine. Carries rsp_sat only when
// ASGN_BINOP_SAT_EN is defined.
interface asgn_binop_acc_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_acc;
  logic             rsp_dz;
  logic             rsp_err;
`ifdef ASGN_BINOP_SAT_EN
  logic             rsp_sat;
`endif

  modport master (
`ifdef ASGN_BINOP_SAT_EN
    input  rsp_sat,
`endif
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_acc, rsp_dz, rsp_err
  );

  modport slave (
`ifdef ASGN_BINOP_SAT_EN
    output rsp_sat,
`endif
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_acc, rsp_dz, rsp_err
  );

endinterface

// File: rtl/asgn_binop_div.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, WIDTH cycles after start.
// Final quotient/remainder are presented combinationally on the done_c cycle.
module asgn_binop_div #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_c,
  output logic [WIDTH-1:0] quotient_c,
  output logic [WIDTH-1:0] remainder_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;

  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // With divisor 0 every trial subtract succeeds: quotient becomes all ones and the
  // remainder ends up equal to the dividend, which is exactly the required dz behaviour.
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    take    = (trial >= {1'b0, dsr});
    rem_nxt = take ? WIDTH'(trial - {1'b0, dsr}) : WIDTH'(trial);
    quo_nxt = {quo[WIDTH-2:0], take};
  end

  assign done_c      = busy && (cnt == CNT_W'(WIDTH - 1));
  assign quotient_c  = quo_nxt;
  assign remainder_c = rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dsr  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quo  <= dividend;
      dsr  <= divisor;
    end else if (busy) begin
      rem  <= rem_nxt;
      quo  <= quo_nxt;
      cnt  <= CNT_W'(cnt + CNT_W'(1));
      if (done_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/asgn_binop_acc.sv
// Sequential `acc op= data` executor: single-cycle ALU plus iterative DIV/MOD, one response per command.
// Define ASGN_BINOP_SAT_EN for saturating ADD/SUB/MUL and the rsp_sat flag.
import asgn_binop_pkg::*;

module asgn_binop_acc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  asgn_binop_acc_if.slave        bus
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic             cmd_ready;
  logic             rsp_valid;
  logic             rsp_dz;
  logic             rsp_err;
  logic             div_is_mod;
  logic             div_dz;
`ifdef ASGN_BINOP_SAT_EN
  logic             rsp_sat;
  logic             alu_sat;
`endif

  logic             accept_c;
  logic             start_div_c;
  logic [WIDTH-1:0] alu_acc;
  logic             alu_err;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [PW-1:0]    prod;
  logic             shift_oob;

  logic             div_done_c;
  logic [WIDTH-1:0] div_quo_c;
  logic [WIDTH-1:0] div_rem_c;

  assign accept_c    = (state == IDLE) && bus.cmd_valid;
  assign start_div_c = accept_c && is_divmod(bus.cmd_op);

  asgn_binop_div #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_div_c),
    .dividend    (acc),
    .divisor     (bus.cmd_data),
    .done_c      (div_done_c),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c)
  );

  // Single-cycle ALU, evaluated on the operands offered at acceptance.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, bus.cmd_data};
    diff      = {1'b0, acc} - {1'b0, bus.cmd_data};
    prod      = PW'(acc) * PW'(bus.cmd_data);
    shift_oob = (32'(bus.cmd_data) >= WIDTH);
    alu_acc   = acc;
    alu_err   = 1'b0;
`ifdef ASGN_BINOP_SAT_EN
    alu_sat   = 1'b0;
`endif
    case (bus.cmd_op)
      OP_LOAD: alu_acc = bus.cmd_data;
      OP_ADD: begin
        alu_acc = sum[WIDTH-1:0];
`ifdef ASGN_BINOP_SAT_EN
        if (sum[WIDTH]) begin
          alu_acc = '1;
          alu_sat = 1'b1;
        end
`endif
      end
      OP_SUB: begin
        alu_acc = diff[WIDTH-1:0];
`ifdef ASGN_BINOP_SAT_EN
        if (diff[WIDTH]) begin
          alu_acc = '0;
          alu_sat = 1'b1;
        end
`endif
      end
      OP_MUL: begin
        alu_acc = prod[WIDTH-1:0];
`ifdef ASGN_BINOP_SAT_EN
        if (|prod[PW-1:WIDTH]) begin
          alu_acc = '1;
          alu_sat = 1'b1;
        end
`endif
      end
      OP_AND:           alu_acc = acc & bus.cmd_data;
      OP_OR:            alu_acc = acc | bus.cmd_data;
      OP_XOR:           alu_acc = acc ^ bus.cmd_data;
      OP_SHL, OP_SSHL:  alu_acc = shift_oob ? '0 : (acc << bus.cmd_data);
      OP_SHR, OP_SSHR:  alu_acc = shift_oob ? '0 : (acc >> bus.cmd_data);
      default:          alu_err = (bus.cmd_op > OP_LAST_LEGAL);
    endcase
  end

  // Engine FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_dz     <= 1'b0;
      rsp_err    <= 1'b0;
      div_is_mod <= 1'b0;
      div_dz     <= 1'b0;
`ifdef ASGN_BINOP_SAT_EN
      rsp_sat    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_div_c) begin
            state      <= DIV;
            cmd_ready  <= 1'b0;
            div_is_mod <= (bus.cmd_op == OP_MOD);
            div_dz     <= (bus.cmd_data == '0);
          end else if (accept_c) begin
            state     <= RESP;
            cmd_ready <= 1'b0;
            acc       <= alu_acc;
            rsp_valid <= 1'b1;
            rsp_dz    <= 1'b0;
            rsp_err   <= alu_err;
`ifdef ASGN_BINOP_SAT_EN
            rsp_sat   <= alu_sat;
`endif
          end
        end
        DIV: begin
          if (div_done_c) begin
            state     <= RESP;
            acc       <= div_is_mod ? div_rem_c : div_quo_c;
            rsp_valid <= 1'b1;
            rsp_dz    <= div_dz;
            rsp_err   <= 1'b0;
`ifdef ASGN_BINOP_SAT_EN
            rsp_sat   <= 1'b0;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_acc   = acc;
  assign bus.rsp_dz    = rsp_dz;
  assign bus.rsp_err   = rsp_err;
`ifdef ASGN_BINOP_SAT_EN
  assign bus.rsp_sat   = rsp_sat;
`endif

endmodule

// File: tb/tb_asgn_binop_acc.sv
// Self-checking bench for asgn_binop_acc: directed vector table, hand-written corner sequences,
// and randomized commands against an arithmetic reference model.
module tb_asgn_binop_acc;

  localparam int unsigned W    = 4;
  localparam int          MAXV = (1 << W) - 1;
`ifdef ASGN_BINOP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  asgn_binop_acc_if #(.WIDTH(W)) bif ();

  asgn_binop_acc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;
  int m_acc  = 0;

  typedef struct {
    int op;
    int data;
    int acc;
    int dz;
    int err;
    int sat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input int op, input int d, input int a, input int dz, input int err,
                         input int sat);
    vec_t v;
    v.op = op; v.data = d; v.acc = a; v.dz = dz; v.err = err; v.sat = sat;
    tbl.push_back(v);
  endtask

  // Reference: the opcode rules written as plain integer arithmetic.
  function automatic void model(input int op, input int d, input int a,
                                output int r, output int dz, output int err, output int sat);
    int full;
    r = a; dz = 0; err = 0; sat = 0;
    case (op)
      0: r = d;
      1: begin
        full = a + d;
        if (full > MAXV) begin
          r = SAT ? MAXV : full - (MAXV + 1); sat = SAT;
        end else r = full;
      end
      2: begin
        full = a - d;
        if (full < 0) begin
          r = SAT ? 0 : full + (MAXV + 1); sat = SAT;
        end else r = full;
      end
      3: begin
        full = a * d;
        if (full > MAXV) begin
          r = SAT ? MAXV : full % (MAXV + 1); sat = SAT;
        end else r = full;
      end
      4: begin dz = (d == 0); r = (d == 0) ? MAXV : a / d; end
      5: begin dz = (d == 0); r = (d == 0) ? a : a % d; end
      6: r = a & d;
      7: r = a | d;
      8: r = a ^ d;
      9, 11: r = (d >= W) ? 0 : (a << d) & MAXV;
      10, 12: r = (d >= W) ? 0 : a >> d;
      default: err = 1;
    endcase
  endfunction

  // Issue one command, measure latency, check response, optionally stall the consumer.
  task automatic run(input int op, input int data, input int e_acc, input int e_dz,
                     input int e_err, input int e_sat, input int hold, input bit poke,
                     input string nm);
    int lat;
    int t;
    t = 0;
    while (!bif.cmd_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!bif.cmd_ready) chk({nm, "_ready_timeout"}, 0, 1);
    bif.rsp_ready = (hold == 0);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 4'(op);
    bif.cmd_data  = W'(data);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    lat = 1;
    while (!bif.rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_latency"}, lat, (op == 4 || op == 5) ? int'(W) + 1 : 1);
    chk({nm, "_acc"}, int'(bif.rsp_acc), e_acc);
    chk({nm, "_dz"},  int'(bif.rsp_dz), e_dz);
    chk({nm, "_err"}, int'(bif.rsp_err), e_err);
`ifdef ASGN_BINOP_SAT_EN
    chk({nm, "_sat"}, int'(bif.rsp_sat), e_sat);
`else
    if (e_sat != 0) chk({nm, "_sat_unexpected"}, 0, e_sat);
`endif
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = 4'd0;
        bif.cmd_data  = W'(e_acc ^ MAXV);
      end
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, int'(bif.rsp_valid), 1);
      chk({nm, "_hold_acc"},   int'(bif.rsp_acc), e_acc);
      chk({nm, "_hold_ready"}, int'(bif.cmd_ready), 0);
    end
    bif.cmd_valid = 1'b0;
    bif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_consumed"}, int'({bif.rsp_valid, bif.cmd_ready}), 1);
  endtask

  task automatic run_model(input int op, input int data, input int hold, input bit poke,
                           input string nm);
    int r, dz, err, sat;
    model(op, data, m_acc, r, dz, err, sat);
    run(op, data, r, dz, err, sat, hold, poke, nm);
    m_acc = r;
  endtask

  initial begin
    int seen;
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = '0;
    bif.cmd_data  = '0;
    bif.rsp_ready = 1'b1;

    // Directed vectors: op, data, expected acc / dz / err / sat.
    add_vec(0, 5, 5, 0, 0, 0);
    add_vec(1, 3, 8, 0, 0, 0);
    add_vec(1, 9, SAT ? 15 : 1, 0, 0, SAT ? 1 : 0);
    add_vec(0, 13, 13, 0, 0, 0);
    add_vec(4, 4, 3, 0, 0, 0);
    add_vec(0, 13, 13, 0, 0, 0);
    add_vec(5, 4, 1, 0, 0, 0);
    add_vec(0, 6, 6, 0, 0, 0);
    add_vec(4, 0, 15, 1, 0, 0);
    add_vec(0, 6, 6, 0, 0, 0);
    add_vec(5, 0, 6, 1, 0, 0);
    add_vec(0, 9, 9, 0, 0, 0);
    add_vec(12, 1, 4, 0, 0, 0);
    add_vec(0, 9, 9, 0, 0, 0);
    add_vec(9, 2, 4, 0, 0, 0);
    add_vec(0, 9, 9, 0, 0, 0);
    add_vec(10, 4, 0, 0, 0, 0);
    add_vec(14, 7, 0, 0, 1, 0);
    add_vec(0, 3, 3, 0, 0, 0);
    add_vec(2, 5, SAT ? 0 : 14, 0, 0, SAT ? 1 : 0);
    add_vec(0, 5, 5, 0, 0, 0);
    add_vec(3, 5, SAT ? 15 : 9, 0, 0, SAT ? 1 : 0);
    add_vec(0, 12, 12, 0, 0, 0);
    add_vec(6, 10, 8, 0, 0, 0);
    add_vec(7, 3, 11, 0, 0, 0);
    add_vec(8, 15, 4, 0, 0, 0);
    add_vec(11, 1, 8, 0, 0, 0);
    add_vec(13, 2, 8, 0, 1, 0);

    #17 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_cmd_ready", int'(bif.cmd_ready), 1);
    chk("reset_rsp_valid", int'(bif.rsp_valid), 0);
    chk("reset_rsp_acc",   int'(bif.rsp_acc), 0);
    chk("reset_rsp_flags", int'({bif.rsp_dz, bif.rsp_err}), 0);

    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].data, tbl[i].acc, tbl[i].dz, tbl[i].err, tbl[i].sat, 0, 1'b0,
          $sformatf("vec%0d", i));
      m_acc = tbl[i].acc;
    end

    // Backpressure: 3 stalled cycles with a cmd_valid pulse that must be ignored.
    run_model(0, 7, 3, 1'b1, "bp_load");
    run_model(1, 0, 0, 1'b0, "bp_after");

    // Reset in the second DIV cycle discards the division and issues no response.
    run_model(0, 13, 0, 1'b0, "rst_load");
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 4'd4;
    bif.cmd_data  = W'(4);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd_ready", int'(bif.cmd_ready), 1);
    chk("midrst_rsp_valid", int'(bif.rsp_valid), 0);
    chk("midrst_rsp_acc",   int'(bif.rsp_acc), 0);
    chk("midrst_flags",     int'({bif.rsp_dz, bif.rsp_err}), 0);
    #3 rst_n = 1'b1;
    m_acc = 0;
    seen = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(posedge clk); #1;
      if (bif.rsp_valid) seen++;
    end
    chk("midrst_no_response", seen, 0);
    chk("midrst_ready_after", int'(bif.cmd_ready), 1);
    run_model(1, 0, 0, 1'b0, "midrst_acc_zero");

    // Randomized commands with random consumer stalls.
    for (int n = 0; n < 150; n++) begin
      int op, d, h;
      op = int'($urandom_range(0, 15));
      d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MAXV));
      h  = int'($urandom_range(0, 2));
      run_model(op, d, h, 1'(($urandom_range(0, 1))), $sformatf("rnd%0d_op%0d", n, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
